irrigation_zone_scheduler: RTL

Sequences up to NZONES irrigation valves through one shared two-digit BCD seconds countdown. Per-zone watering durations are programmed in BCD. A start command runs every enabled zone in ascending index order, with a one-second all-valves-off settling gap between zones. The block sits between the operator/config interface and the valve drivers, and drives the 7-segment time display.

---
 rtl/irrigation_zone_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/irrigation_zone_scheduler.sv
// irrigation_zone_scheduler: runs the enabled irrigation zones one at a time, in
// ascending index order, each for its programmed BCD duration in seconds. Zones are
// separated by a one-second gap with all valves off.
// Ports: clk/rst (rst is asynchronous, active-high); start/abort commands; zone_en
// mask; dur_wr/dur_zone/dur_bcd duration programming; valve one-hot drive; busy;
// zone_idx; time_bcd remaining seconds; done and err one-cycle pulses.
module irrigation_zone_scheduler #(
   parameter int NZONES   = 4,
   parameter int TICK_DIV = 1000,
   localparam int ZW = $clog2(NZONES),
   localparam int PW = $clog2(TICK_DIV)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [NZONES-1:0] zone_en,
   input  logic              dur_wr,
   input  logic [ZW-1:0]     dur_zone,
   input  logic [7:0]        dur_bcd,
   output logic [NZONES-1:0] valve,
   output logic              busy,
   output logic [ZW-1:0]     zone_idx,
   output logic [7:0]        time_bcd,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE} state_t;

   state_t            state, state_nxt;
   logic [7:0]        dur [NZONES];
   logic [NZONES-1:0] pending;
   logic [PW-1:0]     presc;
   logic              tick;
   logic [ZW-1:0]     sel;
   logic [7:0]        sel_dur;
   logic              bcd_ok;
   logic              wr_ok;
   logic              abort_go;

   // BCD decrement by one second; callers never pass 00.
   function automatic logic [7:0] bcd_dec(input logic [7:0] v);
      if (v[3:0] != 4'd0)
         return {v[7:4], v[3:0] - 4'd1};
      else
         return {v[7:4] - 4'd1, 4'd9};
   endfunction

   assign tick     = (presc == PW'(TICK_DIV - 1));
   assign busy     = (state == LOAD) || (state == RUN) || (state == GAP);
   assign done     = (state == DONE);
   assign bcd_ok   = (dur_bcd[7:4] <= 4'd9) && (dur_bcd[3:0] <= 4'd9);
   assign wr_ok    = dur_wr && !busy && bcd_ok;
   assign abort_go = abort && (state != IDLE);
   assign sel_dur  = dur[sel];

   // Lowest set bit of the pending mask; scanning downwards lets the lowest index win.
   always_comb begin
      sel = '0;
      for (int i = NZONES - 1; i >= 0; i--) begin
         if (pending[i]) sel = ZW'(i);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start && (zone_en != '0)) state_nxt = LOAD;
         LOAD: begin
            if (pending == '0)          state_nxt = DONE;
            else if (sel_dur != 8'h00)  state_nxt = RUN;
            // zero-duration zone: stay in LOAD and pick the next pending zone
         end
         RUN:  if (tick && (time_bcd == 8'h01)) state_nxt = GAP;
         GAP:  if (tick) state_nxt = LOAD;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      // abort outranks every other transition
      if (abort_go) state_nxt = IDLE;
   end

   // Duration registers; writes are refused while a cycle is in progress.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NZONES; i++) dur[i] <= 8'h10;
         err <= 1'b0;
      end else begin
         err <= dur_wr && !busy && !bcd_ok;
         for (int i = 0; i < NZONES; i++) begin
            if (wr_ok && (dur_zone == ZW'(i))) dur[i] <= dur_bcd;
         end
      end
   end

   // Sequencing datapath: pending mask, prescaler, countdown, valve drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending  <= '0;
         presc    <= '0;
         time_bcd <= 8'h00;
         valve    <= '0;
         zone_idx <= '0;
      end else if (abort_go) begin
         pending  <= '0;
         presc    <= '0;
         time_bcd <= 8'h00;
         valve    <= '0;
      end else begin
         case (state)
            IDLE: begin
               presc <= '0;
               if (start && (zone_en != '0)) pending <= zone_en;
            end
            LOAD: begin
               if (pending != '0) begin
                  pending  <= pending & ~(NZONES'(1) << sel);
                  zone_idx <= sel;
                  if (sel_dur != 8'h00) begin
                     time_bcd <= sel_dur;
                     presc    <= '0;
                     valve    <= NZONES'(1) << sel;
                  end
               end
            end
            RUN: begin
               presc <= tick ? '0 : presc + PW'(1);
               if (tick) begin
                  time_bcd <= bcd_dec(time_bcd);
                  if (time_bcd == 8'h01) valve <= '0;
               end
            end
            GAP: presc <= tick ? '0 : presc + PW'(1);
            DONE: time_bcd <= 8'h00;
            default: ;
         endcase
      end
   end

endmodule
